// File: rtl/seq_stage_controller_pkg.sv
// Shared definitions for the Y86-64 SEQ sequencer: instruction codes, status
// codes, sequencer state encoding and the set of memory-touching instructions.
package seq_stage_controller_pkg;

   // Instruction codes (icode field of the first instruction byte)
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Processor status codes
   localparam logic [1:0] STAT_AOK = 2'd0;
   localparam logic [1:0] STAT_HLT = 2'd1;
   localparam logic [1:0] STAT_ADR = 2'd2;
   localparam logic [1:0] STAT_INS = 2'd3;

   // Sequencer states
   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_DECODE    = 4'd2,
      ST_EXECUTE   = 4'd3,
      ST_MEMORY    = 4'd4,
      ST_WRITEBACK = 4'd5,
      ST_PCUPD     = 4'd6,
      ST_PAUSE     = 4'd7,
      ST_HALTED    = 4'd8
   } state_e;

   // True for instructions that access data memory in the MEMORY stage
   function automatic logic touches_mem(input logic [3:0] ic);
      logic r;
      case (ic)
         IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: r = 1'b1;
         default:                                      r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_stage_controller_pc_select.sv
// Combinational next-PC selection for a completed instruction. Kept separate so
// the pipelined PC predictor can reuse the same selection rules.
module pc_select
   import seq_stage_controller_pkg::*;
(
   input  logic [3:0]  icode,
   input  logic        cnd,
   input  logic [63:0] val_c,
   input  logic [63:0] val_m,
   input  logic [63:0] val_p,
   output logic [63:0] new_pc
);

   // Pick the target: call and taken jumps go to valC, ret to the popped address
   always_comb begin
      new_pc = val_p;
      case (icode)
         ICALL: new_pc = val_c;
         IJXX: begin
            if (cnd) begin
               new_pc = val_c;
            end else begin
               new_pc = val_p;
            end
         end
         IRET:    new_pc = val_m;
         default: new_pc = val_p;
      endcase
   end

endmodule

// File: rtl/seq_stage_controller.sv
// Multi-cycle SEQ sequencer. Walks each instruction through six one-cycle
// stages, owns the architectural PC, counts retired instructions and tracks
// the processor status. Stage strobes are registered from the next state so
// each one is a clean one-cycle pulse aligned with its stage.
module seq_stage_controller
   import seq_stage_controller_pkg::*;
#(
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter int unsigned CNT_W     = 32'd32,
   parameter int unsigned MAX_INSTR = 32'd0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step_mode,
   input  logic             step,
   input  logic [3:0]       icode,
   input  logic [63:0]      valC,
   input  logic [63:0]      valP,
   input  logic             imem_error,
   input  logic [63:0]      valM,
   input  logic             dmem_error,
   input  logic             cnd,
   output logic [63:0]      PC,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             wb_en,
   output logic [1:0]       stat,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSTR);
   localparam logic             WD_ON   = (MAX_INSTR != 32'd0);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   state_e           state_q, state_d;
   logic [63:0]      pc_q, pc_d;
   logic [1:0]       stat_q, stat_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [3:0]       icode_q, icode_d;
   logic [63:0]      valc_q, valc_d;
   logic [63:0]      valp_q, valp_d;
   logic [63:0]      valm_q, valm_d;
   logic             cnd_q, cnd_d;
   logic             fetch_en_q, fetch_en_d;
   logic             decode_en_q, decode_en_d;
   logic             exec_en_q, exec_en_d;
   logic             mem_en_q, mem_en_d;
   logic             wb_en_q, wb_en_d;
   logic             halted_q, halted_d;
   logic [63:0]      new_pc;

   pc_select u_pc_select (
      .icode  (icode_q),
      .cnd    (cnd_q),
      .val_c  (valc_q),
      .val_m  (valm_q),
      .val_p  (valp_q),
      .new_pc (new_pc)
   );

   // Next-state, datapath latch and strobe computation
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      stat_d    = stat_q;
      retired_d = retired_q;
      icode_d   = icode_q;
      valc_d    = valc_q;
      valp_d    = valp_q;
      valm_d    = valm_q;
      cnd_d     = cnd_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // Fault checks in priority order; a faulting fetch never retires
            if (imem_error) begin
               stat_d  = STAT_ADR;
               state_d = ST_HALTED;
            end else if (icode > IPOPQ) begin
               stat_d  = STAT_INS;
               state_d = ST_HALTED;
            end else if (icode == IHALT) begin
               stat_d  = STAT_HLT;
               state_d = ST_HALTED;
            end else begin
               icode_d = icode;
               valc_d  = valC;
               valp_d  = valP;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: state_d = ST_EXECUTE;
         ST_EXECUTE: begin
            cnd_d   = cnd;
            state_d = ST_MEMORY;
         end
         ST_MEMORY: begin
            valm_d = valM;
            // Data errors only matter for instructions that touched memory
            if (dmem_error && touches_mem(icode_q)) begin
               stat_d  = STAT_ADR;
               state_d = ST_HALTED;
            end else begin
               state_d = ST_WRITEBACK;
            end
         end
         ST_WRITEBACK: state_d = ST_PCUPD;
         ST_PCUPD: begin
            pc_d      = new_pc;
            retired_d = retired_q + CNT_ONE;
            if (WD_ON && (retired_d == MAX_CNT)) begin
               stat_d  = STAT_HLT;
               state_d = ST_HALTED;
            end else if (step_mode) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_PAUSE: begin
            if (step) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase

      fetch_en_d  = (state_d == ST_FETCH);
      decode_en_d = (state_d == ST_DECODE);
      exec_en_d   = (state_d == ST_EXECUTE);
      mem_en_d    = (state_d == ST_MEMORY) && touches_mem(icode_d);
      wb_en_d     = (state_d == ST_WRITEBACK);
      halted_d    = (state_d == ST_HALTED);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC;
         stat_q      <= STAT_AOK;
         retired_q   <= '0;
         icode_q     <= 4'd0;
         valc_q      <= 64'd0;
         valp_q      <= 64'd0;
         valm_q      <= 64'd0;
         cnd_q       <= 1'b0;
         fetch_en_q  <= 1'b0;
         decode_en_q <= 1'b0;
         exec_en_q   <= 1'b0;
         mem_en_q    <= 1'b0;
         wb_en_q     <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         stat_q      <= stat_d;
         retired_q   <= retired_d;
         icode_q     <= icode_d;
         valc_q      <= valc_d;
         valp_q      <= valp_d;
         valm_q      <= valm_d;
         cnd_q       <= cnd_d;
         fetch_en_q  <= fetch_en_d;
         decode_en_q <= decode_en_d;
         exec_en_q   <= exec_en_d;
         mem_en_q    <= mem_en_d;
         wb_en_q     <= wb_en_d;
         halted_q    <= halted_d;
      end
   end

   assign PC        = pc_q;
   assign stat      = stat_q;
   assign retired   = retired_q;
   assign fetch_en  = fetch_en_q;
   assign decode_en = decode_en_q;
   assign exec_en   = exec_en_q;
   assign mem_en    = mem_en_q;
   assign wb_en     = wb_en_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Bench for seq_stage_controller. A driver plays the role of fetch/execute/
// memory, computes each instruction's outcome from the architectural rules and
// queues it; a monitor pops one expectation per fetch strobe or halt entry.
module tb_seq_stage_controller;

   localparam int MAXI = 12;

   logic        clk = 1'b0;
   logic        rst, start, step_mode, step, imem_error, dmem_error, cnd;
   logic [3:0]  icode;
   logic [63:0] valC, valP, valM, PC;
   logic        fetch_en, decode_en, exec_en, mem_en, wb_en, halted;
   logic [1:0]  stat;
   logic [31:0] retired;

   always #5 clk = ~clk;

   seq_stage_controller #(.RESET_PC(64'd0), .CNT_W(32), .MAX_INSTR(MAXI)) dut (
      .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
      .icode(icode), .valC(valC), .valP(valP), .imem_error(imem_error),
      .valM(valM), .dmem_error(dmem_error), .cnd(cnd), .PC(PC),
      .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
      .mem_en(mem_en), .wb_en(wb_en), .stat(stat), .halted(halted),
      .retired(retired)
   );

   typedef struct {
      logic [63:0] pc;
      logic [1:0]  stat;
      logic        halted;
      logic [31:0] ret;
      logic [19:0] strb;   // strobe counts {fetch,decode,exec,mem,wb}, 4 bits each
      int          cyc;    // cycles since previous event, 0 = not checked
   } exp_t;

   typedef struct {
      logic [3:0]  ic;
      logic [63:0] vc, vp, vm;
      logic        c, ie, de;
   } ins_t;

   exp_t q[$];
   ins_t script[$];
   int   total = 0;
   int   bad = 0;
   bit   done = 1'b0;
   bit   mon_on = 1'b0;

   logic [63:0] m_pc;
   logic [1:0]  m_stat;
   logic        m_halted;
   logic [31:0] m_ret;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic ins_t mk(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                               input logic [63:0] vm, input logic c, input logic ie, input logic de);
      ins_t r;
      r.ic = ic; r.vc = vc; r.vp = vp; r.vm = vm; r.c = c; r.ie = ie; r.de = de;
      return r;
   endfunction

   function automatic ins_t rand_ins();
      ins_t r;
      int   p;
      p = $urandom_range(0, 99);
      if (p < 3)      r.ic = 4'h0;
      else if (p < 6) r.ic = 4'($urandom_range(12, 15));
      else            r.ic = 4'($urandom_range(1, 11));
      r.vc = {$urandom, $urandom};
      r.vp = m_pc + 64'($urandom_range(1, 10));
      r.vm = {$urandom, $urandom};
      r.c  = 1'($urandom_range(0, 1));
      r.ie = ($urandom_range(0, 39) == 0);
      r.de = ($urandom_range(0, 7) == 0);
      return r;
   endfunction

   task automatic monitor();
      exp_t e;
      logic hp = 1'b0;
      int   nf = 0, nd = 0, ne = 0, nm = 0, nw = 0, cyc = 0;
      while (!done) begin
         @(negedge clk);
         if (!mon_on) begin
            hp = 1'b0; nf = 0; nd = 0; ne = 0; nm = 0; nw = 0; cyc = 0;
         end else begin
            chk("strobe_onehot", 64'($countones({fetch_en, decode_en, exec_en, mem_en, wb_en}) <= 1), 64'd1);
            if (fetch_en || (halted && !hp)) begin
               if (q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_event: got fetch_en=%0b halted=%0b PC=%0h expected no event", fetch_en, halted, PC);
               end else begin
                  e = q.pop_front();
                  chk("pc", PC, e.pc);
                  chk("stat", 64'(stat), 64'(e.stat));
                  chk("halted", 64'(halted), 64'(e.halted));
                  chk("retired", 64'(retired), 64'(e.ret));
                  chk("strobe_counts", 64'({4'(nf), 4'(nd), 4'(ne), 4'(nm), 4'(nw)}), 64'(e.strb));
                  if (e.cyc != 0) chk("latency", 64'(cyc), 64'(e.cyc));
               end
               nf = 0; nd = 0; ne = 0; nm = 0; nw = 0; cyc = 0;
            end
            nf += int'(fetch_en); nd += int'(decode_en); ne += int'(exec_en);
            nm += int'(mem_en);   nw += int'(wb_en);
            cyc++;
            hp = halted;
         end
      end
   endtask

   task automatic do_reset();
      mon_on = 1'b0;
      rst = 1'b1; start = 1'b0; step = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_pc", PC, 64'd0);
      chk("rst_stat", 64'(stat), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      chk("rst_retired", 64'(retired), 64'd0);
      chk("rst_strobes", 64'({fetch_en, decode_en, exec_en, mem_en, wb_en}), 64'd0);
      q.delete();
      mon_on = 1'b1;
   endtask

   task automatic run(input bit smode, input bit rnd, input int abort_at);
      ins_t it;
      exp_t e;
      int   k, n, tmo;
      bit   touch;
      do_reset();
      step_mode = smode;
      m_pc = 64'd0; m_stat = 2'd0; m_halted = 1'b0; m_ret = 32'd0;
      e.pc = 64'd0; e.stat = 2'd0; e.halted = 1'b0; e.ret = 32'd0; e.strb = 20'd0; e.cyc = 0;
      q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!m_halted) begin
         tmo = 0;
         while (!(fetch_en || halted) && tmo < 40) begin
            @(negedge clk);
            tmo++;
         end
         if (!fetch_en) begin
            total++; bad++;
            $display("FAIL fetch_wait: got fetch_en=%0b halted=%0b expected a fetch strobe", fetch_en, halted);
            break;
         end
         if (script.size() != 0) it = script.pop_front();
         else if (rnd)           it = rand_ins();
         else                    it = mk(4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
         icode = it.ic; valC = it.vc; valP = it.vp; valM = it.vm;
         cnd = it.c; imem_error = it.ie; dmem_error = it.de;
         // Reference outcome of this instruction
         touch = (it.ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
         k = $urandom_range(0, 3);
         if (it.ie || it.ic > 4'hB || it.ic == 4'h0) begin
            m_stat = it.ie ? 2'd2 : ((it.ic > 4'hB) ? 2'd3 : 2'd1);
            m_halted = 1'b1;
            e.strb = 20'h10000; e.cyc = 1;
         end else if (touch && it.de) begin
            m_stat = 2'd2; m_halted = 1'b1;
            e.strb = 20'h11110; e.cyc = 4;
         end else begin
            if (it.ic == 4'h8 || (it.ic == 4'h7 && it.c)) m_pc = it.vc;
            else if (it.ic == 4'h9)                       m_pc = it.vm;
            else                                          m_pc = it.vp;
            m_ret = m_ret + 32'd1;
            e.strb = {4'd1, 4'd1, 4'd1, touch ? 4'd1 : 4'd0, 4'd1};
            if (m_ret == 32'(MAXI)) begin
               m_stat = 2'd1; m_halted = 1'b1; e.cyc = 6;
            end else begin
               e.cyc = smode ? 7 + k : 6;
            end
         end
         e.pc = m_pc; e.stat = m_stat; e.halted = m_halted; e.ret = m_ret;
         q.push_back(e);
         // Disturb inputs once their sampling stage is over
         for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            if (j == 1) begin
               icode = 4'($urandom); valC = {$urandom, $urandom};
               valP = {$urandom, $urandom}; imem_error = 1'($urandom_range(0, 1));
            end
            if (j == 2 && n == abort_at) begin
               chk("exec_en_before_abort", 64'(exec_en), 64'd1);
               return;
            end
            if (j == 3) cnd = 1'($urandom_range(0, 1));
            if (j == 4) begin
               valM = {$urandom, $urandom}; dmem_error = 1'($urandom_range(0, 1));
            end
         end
         if (smode && !m_halted) begin
            repeat (2 + k) begin
               @(negedge clk);
               start = 1'($urandom_range(0, 1));
            end
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
         end
         start = 1'b0;
         n++;
      end
      script.delete();
      tmo = 0;
      while (q.size() != 0 && tmo < 20) begin
         @(negedge clk);
         tmo++;
      end
      chk("queue_drained", 64'(q.size()), 64'd0);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("halted_absorbing", 64'(halted), 64'(m_halted));
      chk("halted_pc", PC, m_pc);
      chk("halted_stat", 64'(stat), 64'(m_stat));
      chk("halted_retired", 64'(retired), 64'(m_ret));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
      icode = 4'd0; valC = 64'd0; valP = 64'd0; valM = 64'd0;
      imem_error = 1'b0; dmem_error = 1'b0; cnd = 1'b0;
      fork
         monitor();
         begin
            // irmovq; nop; halt
            script.push_back(mk(4'h3, 64'h55, 64'd10, 64'd0, 1'b0, 1'b0, 1'b0));
            script.push_back(mk(4'h1, 64'd0, 64'd11, 64'd0, 1'b0, 1'b0, 1'b0));
            script.push_back(mk(4'h0, 64'd0, 64'd12, 64'd0, 1'b0, 1'b0, 1'b0));
            run(1'b0, 1'b0, -1);
            // jumps taken/not taken, call, ret
            script.push_back(mk(4'h7, 64'h20, 64'h9, 64'd0, 1'b1, 1'b0, 1'b0));
            script.push_back(mk(4'h7, 64'h80, 64'h29, 64'd0, 1'b1, 1'b0, 1'b0));
            script.push_back(mk(4'h7, 64'h20, 64'h89, 64'd0, 1'b1, 1'b0, 1'b0));
            script.push_back(mk(4'h7, 64'h80, 64'h29, 64'd0, 1'b0, 1'b0, 1'b0));
            script.push_back(mk(4'h8, 64'h300, 64'h32, 64'd0, 1'b0, 1'b0, 1'b0));
            script.push_back(mk(4'h9, 64'd0, 64'h301, 64'h1234, 1'b0, 1'b0, 1'b0));
            run(1'b0, 1'b0, -1);
            // invalid instruction, then imem_error outranking halt
            script.push_back(mk(4'hC, 64'd0, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0));
            run(1'b0, 1'b0, -1);
            script.push_back(mk(4'h0, 64'd0, 64'd1, 64'd0, 1'b0, 1'b1, 1'b0));
            run(1'b0, 1'b0, -1);
            // data error on mrmovq, then ignored on nop
            script.push_back(mk(4'h1, 64'd0, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0));
            script.push_back(mk(4'h5, 64'd0, 64'd11, 64'd0, 1'b0, 1'b0, 1'b1));
            run(1'b0, 1'b0, -1);
            script.push_back(mk(4'h1, 64'd0, 64'd1, 64'd0, 1'b0, 1'b0, 1'b1));
            run(1'b0, 1'b0, -1);
            // reset during EXECUTE of the third instruction
            for (int i = 0; i < 4; i++) script.push_back(mk(4'h1, 64'd0, 64'(i + 5), 64'd0, 1'b0, 1'b0, 1'b0));
            run(1'b0, 1'b0, 2);
            script.delete();
            do_reset();
            // nop loop into the retirement watchdog
            for (int i = 0; i < 20; i++) script.push_back(mk(4'h1, 64'd0, 64'(i + 1), 64'd0, 1'b0, 1'b0, 1'b0));
            run(1'b0, 1'b0, -1);
            // single-step mode and random programs
            run(1'b1, 1'b1, -1);
            for (int r = 0; r < 25; r++) run(1'($urandom_range(0, 1)), 1'b1, -1);
            done = 1'b1;
         end
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
